k7aes_core: RTL and testbench
=============================

Name: k7aes_core

Overview:
- Board-level link-exercise core for the Kintex-7 AES board.
- Drives an SFP serial lane and eight PCIe lanes with a PRBS-7 bit stream.
- Checks the SFP lane's received stream (external loopback txp->rxp) for lock and errors.
- Handles SFP control pins and the PCIe fundamental reset; all logic runs in a single clock domain.

Parameters:
- PRBS_SEED, 7'h7F, LFSR reset value; must be nonzero.
- LOCK_COUNT, 16, consecutive correct received bits required to declare lock.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- CLK  in  1  system clock; one serial bit per cycle.
- RESET  in  1  asynchronous, active-high reset.
- PCI_Express_pci_exp_txp/txn  out  8  PCIe lane TX pairs.
- PCI_Express_pci_exp_rxp/rxn  in  8  PCIe lane RX pairs.
- PCIe_Diff_Clk_P/N  in  1  PCIe reference clock pair; reserved for hard IP, unused by core logic.
- PCIe_perstn  in  1  PCIe fundamental reset, active-low, asynchronous to CLK.
- sfp_sgd  in  1  SFP signal detect (1 = light present).
- sfp_txf  in  1  SFP TX fault.
- sfp_rs  out  1  SFP rate select.
- sfp_txd  out  1  SFP TX disable.
- txp/txn  out  1  SFP serial TX pair.
- rxp/rxn  in  1  SFP serial RX pair.
- refclk_p/n  in  1  GT reference clock pair; reserved, unused by core logic.
- link_locked  out  1  SFP RX checker locked.
- err_count  out  ERR_CNT_W  saturating RX bit-error count.
- pcie_link_up  out  1  all 8 PCIe RX pairs differential-valid and perst released.

Behaviour:
- Reset (RESET=1) values:
  - txp=0, txn=1, sfp_txd=1, sfp_rs=0.
  - All PCIe tx pairs 0/0.
  - link_locked=0, err_count=0, pcie_link_up=0.
  - LFSR=PRBS_SEED; all sync flops 0.
- Generator:
  - 7-bit LFSR, polynomial x^7+x^6+1.
  - Each cycle: bit=lfsr[6]; lfsr<={lfsr[5:0], lfsr[6]^lfsr[5]}.
  - Period 127 bits. The LFSR runs continuously once out of reset.
- SFP TX:
  - txp<=bit registered (1-cycle latency from LFSR state); txn is always ~txp.
  - While sfp_txd=1, the pair is held idle at txp=0, txn=1 and the LFSR keeps running.
- SFP control:
  - sfp_txf is synchronized through 2 flops.
  - sfp_txd<=1 while synced txf=1, else 0 (3-cycle assert/deassert latency).
  - sfp_rs<=1 from the first cycle after reset.
- RX sampling:
  - rxp and (rxp!=rxn) are each synchronized through 2 flops, giving rx_bit and rx_valid.
  - Checker enable = rx_valid & synced sfp_sgd (sfp_sgd also 2-flop synchronized).
- Checker:
  - 7-bit history h is shifted with rx_bit every enabled cycle.
  - predicted = h[6]^h[5].
  - match = (rx_bit==predicted) && h!=0; an all-zero history is never a match.
  - Lock counter increments on match and clears on mismatch.
  - link_locked sets when the counter reaches LOCK_COUNT.
  - Any mismatch while locked: increment err_count (saturate at all-ones, never wrap), clear link_locked, restart the counter.
  - Disabled cycles: history and err_count hold; lock counter and link_locked clear.
- PCIe:
  - PCIe_perstn is synchronized through 2 flops.
  - While synced perst is low, all 8 tx pairs = 0/0 (electrical idle) and pcie_link_up=0.
  - After release, every lane drives txp=registered PRBS bit, txn=~txp.
  - pcie_link_up <= synced perst & AND over lanes of synced (rxp[i]!=rxn[i]).
  - An X or equal pair on any lane keeps pcie_link_up=0.
- Reset mid-operation: all state returns immediately to reset values; lock must be re-acquired.

Decomposition:
- Shared package k7aes_pkg: PRBS7 tap constants, default seed, LOCK_COUNT default.
- One natural sub-module: prbs7_checker (history, match, lock counter, error counter), reused if per-PCIe-lane checking is added later.
- Generator and 2-flop synchronizers stay inline.

Test Plan:
- Reset release, loopback rxp=txp/rxn=txn, sfp_sgd=1, sfp_txf=0:
  - sfp_txd falls within 3 cycles; sfp_rs=1.
  - link_locked=1 within 7+LOCK_COUNT+4 cycles; err_count stays 0 over 1000 cycles.
- Locked link, invert one txp->rxp bit:
  - err_count=1 and link_locked=0 within 3 cycles.
  - Relock after LOCK_COUNT good bits.
- sfp_sgd=0 for 50 cycles: link_locked=0, err_count unchanged; relocks after sgd returns to 1.
- sfp_txf pulse high for 20 cycles:
  - sfp_txd high ~3 cycles later; txp=0/txn=1 during the pulse.
  - Checker loses lock; err_count increments by exactly 1.
- PCIe_perstn low: all PCI tx pairs 0/0.
  - After perstn high with all rx pairs driven complementary: pcie_link_up=1 within 3 cycles.
  - One lane with rxp=rxn=0 -> pcie_link_up=0.
- RESET reasserted mid-run: all outputs return to reset values asynchronously; after release, err_count=0 and lock re-acquires.

Source files
------------

// File: rtl/k7aes_pkg.sv
// Shared constants and helpers for the Kintex-7 AES link-exercise core.
// PRBS-7 uses x^7 + x^6 + 1: the feedback taps are bits 6 and 5 of the state.
package k7aes_pkg;

   localparam int PRBS7_W      = 7;
   localparam int PRBS7_TAP_HI = 6;
   localparam int PRBS7_TAP_LO = 5;

   typedef logic [PRBS7_W-1:0] prbs7_t;

   localparam prbs7_t PRBS7_DEFAULT_SEED = 7'h7F;
   localparam int     LOCK_COUNT_DEFAULT = 16;
   localparam int     ERR_CNT_W_DEFAULT  = 16;
   localparam int     PCIE_LANES         = 8;

   // Recurrence bit: the value that enters the register on the next shift.
   function automatic logic prbs7_feedback(input prbs7_t s);
      return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
   endfunction

   // One generator step: shift left, feedback enters at bit 0.
   function automatic prbs7_t prbs7_next(input prbs7_t s);
      return {s[PRBS7_W-2:0], prbs7_feedback(s)};
   endfunction

endpackage

// File: rtl/k7aes_core_prbs7_checker.sv
// PRBS-7 receive checker: rebuilds the recurrence from the received bits,
// tracks lock, and counts bit errors seen while locked (saturating).
module prbs7_checker
   import k7aes_pkg::*;
#(
   parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT,
   parameter int ERR_CNT_W  = ERR_CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 rx_bit,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int                   CNT_W    = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(LOCK_COUNT);
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

   prbs7_t                 hist_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   locked_r;
   logic [ERR_CNT_W-1:0]   err_r;
   logic                   match_s;

   // Compare the incoming bit with the prediction; an all-zero history is a dead state and never matches.
   always_comb begin
      match_s = 1'b0;
      if (hist_r != 7'h00) begin
         match_s = (rx_bit == prbs7_feedback(hist_r));
      end else begin
         match_s = 1'b0;
      end
   end

   // History, lock counter, lock flag and saturating error counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_r   <= 7'h00;
         cnt_r    <= '0;
         locked_r <= 1'b0;
         err_r    <= '0;
      end else if (!en) begin
         // No usable input: keep history and error total, drop lock.
         cnt_r    <= '0;
         locked_r <= 1'b0;
      end else if (match_s) begin
         hist_r <= {hist_r[PRBS7_W-2:0], rx_bit};
         if (cnt_r != CNT_FULL) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (cnt_r >= CNT_LAST) begin
            locked_r <= 1'b1;
         end
      end else begin
         hist_r   <= {hist_r[PRBS7_W-2:0], rx_bit};
         cnt_r    <= '0;
         locked_r <= 1'b0;
         if (locked_r && (err_r != ERR_MAX)) begin
            err_r <= err_r + ERR_ONE;
         end
      end
   end

   assign locked    = locked_r;
   assign err_count = err_r;

endmodule

// File: rtl/k7aes_core.sv
// Kintex-7 AES board link-exercise core: PRBS-7 on the SFP lane and all
// eight PCIe lanes, SFP loopback checking, SFP control and PCIe link status.
module k7aes_core
   import k7aes_pkg::*;
#(
   parameter prbs7_t PRBS_SEED  = PRBS7_DEFAULT_SEED,
   parameter int     LOCK_COUNT = LOCK_COUNT_DEFAULT,
   parameter int     ERR_CNT_W  = ERR_CNT_W_DEFAULT
) (
   input  logic                  CLK,
   input  logic                  RESET,
   output logic [PCIE_LANES-1:0] PCI_Express_pci_exp_txp,
   output logic [PCIE_LANES-1:0] PCI_Express_pci_exp_txn,
   input  logic [PCIE_LANES-1:0] PCI_Express_pci_exp_rxp,
   input  logic [PCIE_LANES-1:0] PCI_Express_pci_exp_rxn,
   input  logic                  PCIe_Diff_Clk_P,
   input  logic                  PCIe_Diff_Clk_N,
   input  logic                  PCIe_perstn,
   input  logic                  sfp_sgd,
   input  logic                  sfp_txf,
   output logic                  sfp_rs,
   output logic                  sfp_txd,
   output logic                  txp,
   output logic                  txn,
   input  logic                  rxp,
   input  logic                  rxn,
   input  logic                  refclk_p,
   input  logic                  refclk_n,
   output logic                  link_locked,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic                  pcie_link_up
);

   prbs7_t                  lfsr_r;
   logic                    prbs_bit_s;
   logic                    txf_meta_r,   txf_sync_r;
   logic                    sgd_meta_r,   sgd_sync_r;
   logic                    rxb_meta_r,   rxb_sync_r;
   logic                    rxv_meta_r,   rxv_sync_r;
   logic                    perst_meta_r, perst_sync_r;
   logic [PCIE_LANES-1:0]   pci_rxv_meta_r, pci_rxv_sync_r;
   logic                    sfp_txd_r;
   logic                    sfp_rs_r;
   logic                    txp_r;
   logic [PCIE_LANES-1:0]   pci_txp_r, pci_txn_r;
   logic                    link_up_r;
   logic                    chk_en_s;
   logic                    unused_refclk_s;

   // Reference clocks belong to the hard IP; the core logic never looks at them.
   assign unused_refclk_s = ^{PCIe_Diff_Clk_P, PCIe_Diff_Clk_N, refclk_p, refclk_n};

   // Free-running PRBS-7 generator; the current output bit is the MSB.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lfsr_r <= PRBS_SEED;
      end else begin
         lfsr_r <= prbs7_next(lfsr_r);
      end
   end

   assign prbs_bit_s = lfsr_r[PRBS7_TAP_HI];

   // Two-flop synchronizers for every input that is asynchronous to CLK.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         txf_meta_r     <= 1'b0;
         txf_sync_r     <= 1'b0;
         sgd_meta_r     <= 1'b0;
         sgd_sync_r     <= 1'b0;
         rxb_meta_r     <= 1'b0;
         rxb_sync_r     <= 1'b0;
         rxv_meta_r     <= 1'b0;
         rxv_sync_r     <= 1'b0;
         perst_meta_r   <= 1'b0;
         perst_sync_r   <= 1'b0;
         pci_rxv_meta_r <= '0;
         pci_rxv_sync_r <= '0;
      end else begin
         txf_meta_r     <= sfp_txf;
         txf_sync_r     <= txf_meta_r;
         sgd_meta_r     <= sfp_sgd;
         sgd_sync_r     <= sgd_meta_r;
         rxb_meta_r     <= rxp;
         rxb_sync_r     <= rxb_meta_r;
         rxv_meta_r     <= (rxp != rxn);
         rxv_sync_r     <= rxv_meta_r;
         perst_meta_r   <= PCIe_perstn;
         perst_sync_r   <= perst_meta_r;
         pci_rxv_meta_r <= PCI_Express_pci_exp_rxp ^ PCI_Express_pci_exp_rxn;
         pci_rxv_sync_r <= pci_rxv_meta_r;
      end
   end

   // SFP control: disable the transmitter while a TX fault is reported, full rate once running.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sfp_txd_r <= 1'b1;
         sfp_rs_r  <= 1'b0;
      end else begin
         sfp_txd_r <= txf_sync_r;
         sfp_rs_r  <= 1'b1;
      end
   end

   // SFP serial TX: registered PRBS bit, idle low while the transmitter is disabled.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         txp_r <= 1'b0;
      end else if (sfp_txd_r) begin
         txp_r <= 1'b0;
      end else begin
         txp_r <= prbs_bit_s;
      end
   end

   // PCIe lanes: electrical idle (0/0) until perst is released, then the same PRBS on every lane.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pci_txp_r <= '0;
         pci_txn_r <= '0;
         link_up_r <= 1'b0;
      end else begin
         if (perst_sync_r) begin
            pci_txp_r <= {PCIE_LANES{prbs_bit_s}};
            pci_txn_r <= {PCIE_LANES{~prbs_bit_s}};
         end else begin
            pci_txp_r <= '0;
            pci_txn_r <= '0;
         end
         link_up_r <= perst_sync_r & (&pci_rxv_sync_r);
      end
   end

   assign chk_en_s = rxv_sync_r & sgd_sync_r;

   prbs7_checker #(
      .LOCK_COUNT (LOCK_COUNT),
      .ERR_CNT_W  (ERR_CNT_W)
   ) u_sfp_checker (
      .clk       (CLK),
      .rst       (RESET),
      .en        (chk_en_s),
      .rx_bit    (rxb_sync_r),
      .locked    (link_locked),
      .err_count (err_count)
   );

   assign txp                     = txp_r;
   assign txn                     = ~txp_r;
   assign sfp_txd                 = sfp_txd_r;
   assign sfp_rs                  = sfp_rs_r;
   assign PCI_Express_pci_exp_txp = pci_txp_r;
   assign PCI_Express_pci_exp_txn = pci_txn_r;
   assign pcie_link_up            = link_up_r;

endmodule

// File: tb/tb_k7aes_core.sv
// Scoreboard bench for k7aes_core: stimulus pushes expectations, a monitor
// process pops them and compares against the DUT on falling clock edges.
module tb_k7aes_core;

   localparam int M_NOW    = 0;  // compare right away (no clock edge)
   localparam int M_AT     = 1;  // compare after dly falling edges
   localparam int M_WITHIN = 2;  // must reach value within dly falling edges
   localparam int M_HOLD   = 3;  // must equal value on each of dly falling edges

   localparam int S_TXP = 0, S_TXN = 1, S_TXD = 2, S_RS = 3, S_LOCK = 4,
                  S_ERR = 5, S_LINK = 6, S_PTXP = 7, S_PTXN = 8, S_PXOR = 9;

   typedef struct {
      int          sel;
      int          mode;
      int          dly;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  pci_txp, pci_txn, pci_rxp, pci_rxn;
   logic        perstn, sgd, txf, rs, txd, txp, txn, rxp, rxn, flip;
   logic        locked, link_up;
   logic [15:0] err_count;

   exp_t sb_q[$];
   bit   busy = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   // External loopback; flip inverts both legs so the pair stays differential-valid.
   assign rxp = txp ^ flip;
   assign rxn = txn ^ flip;

   k7aes_core dut (
      .CLK                     (CLK),
      .RESET                   (RESET),
      .PCI_Express_pci_exp_txp (pci_txp),
      .PCI_Express_pci_exp_txn (pci_txn),
      .PCI_Express_pci_exp_rxp (pci_rxp),
      .PCI_Express_pci_exp_rxn (pci_rxn),
      .PCIe_Diff_Clk_P         (1'b0),
      .PCIe_Diff_Clk_N         (1'b1),
      .PCIe_perstn             (perstn),
      .sfp_sgd                 (sgd),
      .sfp_txf                 (txf),
      .sfp_rs                  (rs),
      .sfp_txd                 (txd),
      .txp                     (txp),
      .txn                     (txn),
      .rxp                     (rxp),
      .rxn                     (rxn),
      .refclk_p                (1'b0),
      .refclk_n                (1'b1),
      .link_locked             (locked),
      .err_count               (err_count),
      .pcie_link_up            (link_up)
   );

   function automatic logic [31:0] get_val(input int sel);
      case (sel)
         S_TXP:   return {31'd0, txp};
         S_TXN:   return {31'd0, txn};
         S_TXD:   return {31'd0, txd};
         S_RS:    return {31'd0, rs};
         S_LOCK:  return {31'd0, locked};
         S_ERR:   return {16'd0, err_count};
         S_LINK:  return {31'd0, link_up};
         S_PTXP:  return {24'd0, pci_txp};
         S_PTXN:  return {24'd0, pci_txn};
         S_PXOR:  return {24'd0, pci_txp ^ pci_txn};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input int sel, input int mode, input int dly,
                       input logic [31:0] exp, input string name);
      exp_t e;
      e.sel = sel; e.mode = mode; e.dly = dly; e.exp = exp; e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb_q.size() != 0 || busy) && guard < 5000) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 5000) begin
         $display("FAIL drain: scoreboard still busy after %0d cycles, want idle", guard);
         $fatal(1, "scoreboard stalled");
      end
   endtask

   // Monitor: pops one expectation at a time and judges it against the DUT.
   initial begin : monitor
      exp_t        e;
      logic [31:0] act;
      bit          ok;
      forever begin
         while (sb_q.size() == 0) #1;
         e    = sb_q.pop_front();
         busy = 1'b1;
         n_vec++;
         act  = '0;
         ok   = 1'b0;
         case (e.mode)
            M_NOW: begin
               #1;
               act = get_val(e.sel);
               ok  = (act == e.exp);
            end
            M_AT: begin
               repeat (e.dly) @(negedge CLK);
               act = get_val(e.sel);
               ok  = (act == e.exp);
            end
            M_WITHIN: begin
               for (int i = 0; i < e.dly && !ok; i++) begin
                  @(negedge CLK);
                  act = get_val(e.sel);
                  ok  = (act == e.exp);
               end
            end
            M_HOLD: begin
               ok = 1'b1;
               for (int i = 0; i < e.dly && ok; i++) begin
                  @(negedge CLK);
                  act = get_val(e.sel);
                  ok  = (act == e.exp);
               end
            end
            default: ok = 1'b0;
         endcase
         if (!ok) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", e.name, act, e.exp);
         end
         busy = 1'b0;
      end
   end

   // Global time limit.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exhausted, want completion");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin : stim
      // txp on the 15 clocks after reset release: one idle 0, then seed 7F stream.
      bit prbs_exp [15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      RESET   = 1'b1;
      perstn  = 1'b0;
      sgd     = 1'b1;
      txf     = 1'b0;
      flip    = 1'b0;
      pci_rxp = 8'hA5;
      pci_rxn = 8'h5A;
      repeat (3) @(negedge CLK);

      // Reset values.
      push(S_TXP,  M_NOW, 0, 32'd0, "rst_txp");
      push(S_TXN,  M_NOW, 0, 32'd1, "rst_txn");
      push(S_TXD,  M_NOW, 0, 32'd1, "rst_sfp_txd");
      push(S_RS,   M_NOW, 0, 32'd0, "rst_sfp_rs");
      push(S_LOCK, M_NOW, 0, 32'd0, "rst_locked");
      push(S_ERR,  M_NOW, 0, 32'd0, "rst_err");
      push(S_LINK, M_NOW, 0, 32'd0, "rst_link_up");
      push(S_PTXP, M_NOW, 0, 32'd0, "rst_pci_txp");
      push(S_PTXN, M_NOW, 0, 32'd0, "rst_pci_txn");
      drain();

      // Release; serial stream, SFP control, loopback lock and clean run.
      RESET = 1'b0;
      foreach (prbs_exp[i]) push(S_TXP, M_AT, 1, {31'd0, prbs_exp[i]}, "txp_prbs");
      push(S_TXD,  M_AT,     0,    32'd0,  "sfp_txd_released");
      push(S_RS,   M_AT,     0,    32'd1,  "sfp_rs_high");
      push(S_PTXP, M_AT,     0,    32'd0,  "pci_txp_idle_perst");
      push(S_LOCK, M_WITHIN, 40,   32'd1,  "initial_lock");
      push(S_ERR,  M_HOLD,   1000, 32'd0,  "err_zero_clean_run");
      push(S_LOCK, M_AT,     0,    32'd1,  "still_locked");
      drain();

      // Single inverted bit on the loopback.
      flip = 1'b1;
      push(S_ERR,  M_WITHIN, 4,  32'd1, "err_after_flip");
      push(S_LOCK, M_AT,     0,  32'd0, "unlock_after_flip");
      push(S_LOCK, M_WITHIN, 40, 32'd1, "relock_after_flip");
      push(S_ERR,  M_AT,     0,  32'd1, "err_stable_after_relock");
      @(negedge CLK);
      flip = 1'b0;
      drain();

      // Signal detect lost for 50 cycles.
      sgd = 1'b0;
      push(S_LOCK, M_WITHIN, 4,  32'd0, "unlock_no_sgd");
      push(S_LOCK, M_HOLD,   40, 32'd0, "stay_unlocked_no_sgd");
      push(S_ERR,  M_AT,     0,  32'd1, "err_hold_no_sgd");
      repeat (50) @(negedge CLK);
      sgd = 1'b1;
      push(S_LOCK, M_WITHIN, 45, 32'd1, "relock_after_sgd");
      push(S_ERR,  M_AT,     0,  32'd1, "err_after_sgd");
      drain();

      // TX fault pulse of 20 cycles.
      txf = 1'b1;
      push(S_TXD,  M_WITHIN, 4,  32'd1, "sfp_txd_on_fault");
      push(S_TXP,  M_HOLD,   10, 32'd0, "txp_idle_on_fault");
      push(S_TXN,  M_AT,     0,  32'd1, "txn_idle_on_fault");
      push(S_LOCK, M_AT,     0,  32'd0, "unlock_on_fault");
      push(S_ERR,  M_AT,     0,  32'd2, "err_on_fault");
      repeat (20) @(negedge CLK);
      txf = 1'b0;
      push(S_TXD,  M_WITHIN, 4,  32'd0, "sfp_txd_fault_clear");
      push(S_LOCK, M_WITHIN, 45, 32'd1, "relock_after_fault");
      push(S_ERR,  M_HOLD,   30, 32'd2, "err_single_increment");
      drain();

      // PCIe: perst release, lane fault, recovery.
      push(S_PTXN, M_AT, 0, 32'd0, "pci_txn_idle_perst");
      push(S_LINK, M_AT, 0, 32'd0, "link_down_perst");
      drain();
      perstn = 1'b1;
      push(S_LINK, M_WITHIN, 3, 32'd1,   "link_up_after_perst");
      push(S_PXOR, M_AT,     1, 32'hFF,  "pci_pairs_complementary");
      drain();
      pci_rxp[3] = 1'b0;
      pci_rxn[3] = 1'b0;
      push(S_LINK, M_WITHIN, 3, 32'd0, "link_down_lane3_equal");
      drain();
      pci_rxn[3] = 1'b1;
      push(S_LINK, M_WITHIN, 3, 32'd1, "link_up_lane3_restored");
      drain();

      // Reset mid-run: outputs go back before any clock edge.
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      push(S_TXN,  M_NOW, 0, 32'd1, "midrst_txn");
      push(S_TXD,  M_NOW, 0, 32'd1, "midrst_sfp_txd");
      push(S_RS,   M_NOW, 0, 32'd0, "midrst_sfp_rs");
      push(S_LOCK, M_NOW, 0, 32'd0, "midrst_locked");
      push(S_ERR,  M_NOW, 0, 32'd0, "midrst_err");
      push(S_LINK, M_NOW, 0, 32'd0, "midrst_link_up");
      push(S_PTXP, M_NOW, 0, 32'd0, "midrst_pci_txp");
      drain();
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      push(S_LOCK, M_WITHIN, 45,  32'd1, "relock_after_reset");
      push(S_LINK, M_AT,     0,   32'd1, "link_up_after_reset");
      push(S_ERR,  M_HOLD,   100, 32'd0, "err_zero_after_reset");
      drain();

      // Perst asserted again: lanes return to electrical idle.
      perstn = 1'b0;
      push(S_PTXP, M_WITHIN, 4, 32'd0, "pci_txp_idle_again");
      push(S_PTXN, M_AT,     0, 32'd0, "pci_txn_idle_again");
      push(S_LINK, M_AT,     0, 32'd0, "link_down_again");
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
